// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush generation, EX operand forwarding,
// data-memory wait tracking with timeout detection, and performance counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             reg_write_E,
  input  logic             result_src_E,
  input  logic             pc_src_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_write_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_write_W,
  input  logic             mreq_M,
  input  logic             dmem_ack,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       forward_a_E,
  output logic [1:0]       forward_b_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              err_set;
  logic              mem_stall;
  logic              load_use;

  assign mem_stall = mreq_M & ~dmem_ack;

  assign load_use = reg_write_E & result_src_E & (rd_E != 5'd0) &
                    ((rd_E == rs1_D) | (rd_E == rs2_D));

  // Prioritised stall/flush: memory wait freezes everything, then redirect, then load-use.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        // EX is frozen, so redirect and load-use get re-evaluated after release.
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (pc_src_E) begin
        // The ID instruction is on the wrong path, so any load-use match is moot.
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // Operand forwarding selects; the younger MEM result wins over WB.
  always_comb begin
    forward_a_E = FWD_RF;
    forward_b_E = FWD_RF;
    if (reg_write_M && (rd_M != 5'd0) && (rd_M == rs1_E)) begin
      forward_a_E = FWD_MEM;
    end else if (reg_write_W && (rd_W != 5'd0) && (rd_W == rs1_E)) begin
      forward_a_E = FWD_WB;
    end
    if (reg_write_M && (rd_M != 5'd0) && (rd_M == rs2_E)) begin
      forward_b_E = FWD_MEM;
    end else if (reg_write_W && (rd_W != 5'd0) && (rd_W == rs2_E)) begin
      forward_b_E = FWD_WB;
    end
  end

  // Memory-wait FSM next state and saturating wait counter.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      S_IDLE: begin
        if (mem_stall) begin
          state_next = S_WAIT;
          wait_next  = WAIT_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt != WAIT_MAX) begin
            wait_next = wait_cnt + WAIT_W'(1);
          end
        end else begin
          state_next = S_IDLE;
          wait_next  = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        wait_next  = '0;
      end
    endcase
    err_set = (wait_next == WAIT_MAX);
  end

  // State, sticky timeout flag and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (err_set) begin
        mem_err <= 1'b1;
      end
      if (stall_F && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_D && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios followed by randomized traffic, all checked
// against a rule-level reference model of the pipeline controller.
module tb_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 32;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic             reg_write_E, result_src_E, pc_src_E;
  logic             reg_write_M, reg_write_W, mreq_M, dmem_ack;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic [1:0]       forward_a_E, forward_b_E;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint m_stall = 0;
  longint m_flush = 0;
  int     m_run   = 0;
  logic   m_err   = 1'b0;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .reg_write_E(reg_write_E), .result_src_E(result_src_E), .pc_src_E(pc_src_E),
    .rd_M(rd_M), .reg_write_M(reg_write_M),
    .rd_W(rd_W), .reg_write_W(reg_write_W),
    .mreq_M(mreq_M), .dmem_ack(dmem_ack),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .forward_a_E(forward_a_E), .forward_b_E(forward_b_E),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,flush_W} from the priority rules.
  function automatic logic [6:0] exp_ctrl();
    logic lu;
    lu = reg_write_E && result_src_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
    if (rst)                 return 7'b0000_000;
    if (mreq_M && !dmem_ack) return 7'b1111_001;
    if (pc_src_E)            return 7'b0000_110;
    if (lu)                  return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  // Expected forward select: youngest matching producer, never for x0.
  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (reg_write_M && rd_M == src) return 2'b10;
    if (reg_write_W && rd_W == src) return 2'b01;
    return 2'b00;
  endfunction

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    logic [6:0] e;
    longint     sat;
    sat = (longint'(1) << CNT_W) - 1;
    #1;
    e = exp_ctrl();
    check("stall_F", 64'(stall_F), 64'(e[6]));
    check("stall_D", 64'(stall_D), 64'(e[5]));
    check("stall_E", 64'(stall_E), 64'(e[4]));
    check("stall_M", 64'(stall_M), 64'(e[3]));
    check("flush_D", 64'(flush_D), 64'(e[2]));
    check("flush_E", 64'(flush_E), 64'(e[1]));
    check("flush_W", 64'(flush_W), 64'(e[0]));
    check("forward_a_E", 64'(forward_a_E), 64'(exp_fwd(rs1_E)));
    check("forward_b_E", 64'(forward_b_E), 64'(exp_fwd(rs2_E)));
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
      m_run   = 0;
      m_err   = 1'b0;
    end else begin
      if (e[6] && m_stall < sat) m_stall++;
      if (e[2] && m_flush < sat) m_flush++;
      if (mreq_M && !dmem_ack) m_run++;
      else m_run = 0;
      if (m_run >= int'(MEM_TIMEOUT)) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    check("mem_err", 64'(mem_err), 64'(m_err));
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    check("flush_events", 64'(flush_events), 64'(m_flush));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    reg_write_E = 0; result_src_E = 0; pc_src_E = 0;
    reg_write_M = 0; reg_write_W = 0; mreq_M = 0; dmem_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit ack_bias;
    idle_inputs();
    do_reset();
    check("reset_stall_cycles", 64'(stall_cycles), 64'd0);
    check("reset_mem_err", 64'(mem_err), 64'd0);

    // Load-use hazard
    rd_E = 5; reg_write_E = 1; result_src_E = 1; rs1_D = 5;
    #1;
    check("lu_stall_F", 64'(stall_F), 64'd1);
    check("lu_flush_E", 64'(flush_E), 64'd1);
    check("lu_flush_D", 64'(flush_D), 64'd0);
    step();
    // x0 destination never hazards
    rd_E = 0; rs1_D = 0;
    #1;
    check("lu_x0_stall_F", 64'(stall_F), 64'd0);
    check("lu_x0_flush_E", 64'(flush_E), 64'd0);
    step();

    // Branch wins over load-use
    do_reset();
    rd_E = 5; rs1_D = 5; pc_src_E = 1;
    #1;
    check("br_flush_D", 64'(flush_D), 64'd1);
    check("br_stall_F", 64'(stall_F), 64'd0);
    step();
    check("br_flush_events", 64'(flush_events), 64'd1);
    idle_inputs();

    // Three-cycle memory wait with a pending branch
    do_reset();
    mreq_M = 1; dmem_ack = 0; pc_src_E = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_stall_M", 64'(stall_M), 64'd1);
      check("mw_flush_W", 64'(flush_W), 64'd1);
      check("mw_flush_D", 64'(flush_D), 64'd0);
      step();
    end
    dmem_ack = 1; pc_src_E = 0;
    #1;
    check("mw_release_stall_F", 64'(stall_F), 64'd0);
    step();
    check("mw_stall_cycles", 64'(stall_cycles), 64'd3);
    // Zero-wait access, then a fresh wait re-entering from scratch
    step();
    dmem_ack = 0;
    step();
    mreq_M = 0;
    step();

    // Timeout
    do_reset();
    mreq_M = 1; dmem_ack = 0;
    for (int i = 1; i <= int'(MEM_TIMEOUT); i++) begin
      step();
      check("to_mem_err", 64'(mem_err), (i == int'(MEM_TIMEOUT)) ? 64'd1 : 64'd0);
    end
    dmem_ack = 1;
    step();
    check("to_sticky", 64'(mem_err), 64'd1);
    mreq_M = 0;
    step();
    do_reset();
    check("to_cleared", 64'(mem_err), 64'd0);

    // Forwarding
    rs1_E = 7; rd_M = 7; reg_write_M = 1; rd_W = 7; reg_write_W = 1;
    #1;
    check("fwd_mem", 64'(forward_a_E), 64'd2);
    step();
    reg_write_M = 0;
    #1;
    check("fwd_wb", 64'(forward_a_E), 64'd1);
    step();
    rs2_E = 0; rd_W = 0;
    #1;
    check("fwd_x0", 64'(forward_b_E), 64'd0);
    step();
    idle_inputs();

    // Reset in the middle of a wait
    mreq_M = 1; dmem_ack = 0;
    for (int i = 0; i < 5; i++) step();
    rst = 1;
    #1;
    check("rw_stall_F", 64'(stall_F), 64'd0);
    check("rw_flush_W", 64'(flush_W), 64'd0);
    step();
    rst = 0; mreq_M = 0;
    step();
    check("rw_stall_cycles", 64'(stall_cycles), 64'd0);
    check("rw_mem_err", 64'(mem_err), 64'd0);
    // Fresh wait after reset must need the full timeout again
    mreq_M = 1;
    for (int i = 0; i < int'(MEM_TIMEOUT); i++) step();
    check("rw_timeout", 64'(mem_err), 64'd1);
    do_reset();
    idle_inputs();

    // Randomized traffic
    ack_bias = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 0) ack_bias = ~ack_bias;
      rst          = ($urandom_range(0, 199) == 0);
      rs1_D        = 5'($urandom_range(0, 3));
      rs2_D        = 5'($urandom_range(0, 3));
      rs1_E        = 5'($urandom_range(0, 3));
      rs2_E        = 5'($urandom_range(0, 3));
      rd_E         = 5'($urandom_range(0, 3));
      rd_M         = 5'($urandom_range(0, 3));
      rd_W         = 5'($urandom_range(0, 3));
      reg_write_E  = 1'($urandom_range(0, 1));
      result_src_E = 1'($urandom_range(0, 1));
      reg_write_M  = 1'($urandom_range(0, 1));
      reg_write_W  = 1'($urandom_range(0, 1));
      pc_src_E     = ($urandom_range(0, 4) == 0);
      mreq_M       = ($urandom_range(0, 9) < 4);
      dmem_ack     = ack_bias ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
